// File: rtl/sid_pkg.sv
// Shared definitions for the SID write sequencer: register map constants,
// sequencer state encoding and the command entry layout.
package sid_pkg;

  // SID register map anchors
  localparam logic [4:0] VOICE1_BASE = 5'h00;
  localparam logic [4:0] VOICE2_BASE = 5'h07;
  localparam logic [4:0] VOICE3_BASE = 5'h0E;
  localparam logic [4:0] FILTER_BASE = 5'h15;
  localparam logic [4:0] REG_VOLUME  = 5'h18;

  // Sequencer states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // One queued command: register write or tick wait
  typedef struct packed {
    logic        is_wait;
    logic [4:0]  addr;
    logic [15:0] data;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/sid_cmd_fifo.sv
// Synchronous command FIFO with flush and occupancy output.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sid_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 22
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign full    = (count == FULL_CNT);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign level   = LW'(count);
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Pointer update; flush empties the queue and wins over push/pop
  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  // Pointer registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents need no reset since pointers gate visibility
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/sid_write_sequencer.sv
// SID write sequencer: drains queued register writes onto the SID bus at
// up to one per clock, with tick-counted waits and a flush-to-mute path.
module sid_write_sequencer
  import sid_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            tick,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_wait,
  input  logic [4:0]                      cmd_addr,
  input  logic [15:0]                     cmd_data,
  input  logic                            flush,
  output logic [4:0]                      sid_a,
  output logic [7:0]                      sid_di,
  output logic                            sid_we,
  output logic                            sid_cs,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] level
);

  state_t          state_q, state_d;
  logic [15:0]     count_q, count_d;
  logic            we_q, we_d;
  logic [4:0]      a_q, a_d;
  logic [7:0]      di_q, di_d;

  cmd_t            push_entry;
  cmd_t            head;
  logic [CMD_W-1:0] head_bits;
  logic            fifo_full, fifo_empty;
  logic            push, pop;

  assign push_entry = {cmd_wait, cmd_addr, cmd_data};
  assign head       = head_bits;
  assign cmd_ready  = !fifo_full && !flush;
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state_q == ST_IDLE) && !fifo_empty && !flush;

  sid_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head_bits),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // Next state, wait counter and bus values; flush overrides everything
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    we_d    = 1'b0;
    a_d     = a_q;
    di_d    = di_q;
    if (flush) begin
      state_d = ST_IDLE;
      count_d = '0;
      we_d    = 1'b1;
      a_d     = REG_VOLUME;
      di_d    = 8'h00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            if (!head.is_wait) begin
              we_d = 1'b1;
              a_d  = head.addr;
              di_d = head.data[7:0];
            end else if (head.data != 16'd0) begin
              count_d = head.data;
              state_d = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (tick) begin
            count_d = count_q - 16'd1;
            if (count_q == 16'd1) state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, counter and SID bus registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      we_q    <= 1'b0;
      a_q     <= '0;
      di_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      we_q    <= we_d;
      a_q     <= a_d;
      di_q    <= di_d;
    end
  end

  assign sid_we = we_q;
  assign sid_cs = we_q;
  assign sid_a  = a_q;
  assign sid_di = di_q;
  assign busy   = (level != '0) || (state_q == ST_WAIT);

endmodule

// File: tb/tb_sid_write_sequencer.sv
// Self-checking bench for sid_write_sequencer: directed scenarios followed by
// randomized traffic, all checked against a queue-based behavioural model.
module tb_sid_write_sequencer;
  import sid_pkg::*;

  localparam int D  = 8;
  localparam int LW = $clog2(D+1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          tick = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_wait = 1'b0;
  logic [4:0]    cmd_addr = '0;
  logic [15:0]   cmd_data = '0;
  logic          flush = 1'b0;
  logic          cmd_ready;
  logic [4:0]    sid_a;
  logic [7:0]    sid_di;
  logic          sid_we, sid_cs, busy;
  logic [LW-1:0] level;

  sid_write_sequencer #(.FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .tick(tick), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_wait(cmd_wait), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .flush(flush), .sid_a(sid_a), .sid_di(sid_di),
    .sid_we(sid_we), .sid_cs(sid_cs), .busy(busy), .level(level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tick_period = 0;
  int we_seen = 0;
  int last_we_cyc = -1;
  int prev_we_cyc = -1;

  // Reference model: pending commands, remaining wait ticks, expected bus
  cmd_t       mq[$];
  bit         m_wait = 0;
  int         wait_left = 0;
  bit         e_we = 0;
  logic [4:0] e_a = '0;
  logic [7:0] e_di = '0;
  bit         accepted = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_output();
    chk("sid_we", 32'(sid_we), 32'(e_we));
    chk("sid_cs", 32'(sid_cs), 32'(e_we));
    chk("sid_a",  32'(sid_a),  32'(e_a));
    chk("sid_di", 32'(sid_di), 32'(e_di));
    chk("level",  32'(level),  32'(mq.size()));
    chk("busy",   32'(busy),   32'((mq.size() != 0) || m_wait));
  endtask

  task automatic model_clear();
    mq.delete();
    m_wait = 0;
    wait_left = 0;
    e_we = 0;
    e_a = '0;
    e_di = '0;
  endtask

  // One clock: predict from the inputs held now, then check after the edge
  task automatic apply_stimulus();
    cmd_t h;
    tick = (tick_period != 0) && (cyc % tick_period == 0);
    #2;
    chk("cmd_ready", 32'(cmd_ready), 32'((mq.size() < D) && !flush));
    accepted = cmd_valid && (mq.size() < D) && !flush;
    e_we = 0;
    if (flush) begin
      mq.delete();
      m_wait = 0;
      wait_left = 0;
      e_we = 1;
      e_a = REG_VOLUME;
      e_di = 8'h00;
    end else if (!m_wait && mq.size() > 0) begin
      h = mq.pop_front();
      if (!h.is_wait) begin
        e_we = 1;
        e_a = h.addr;
        e_di = h.data[7:0];
      end else if (h.data != 0) begin
        m_wait = 1;
        wait_left = int'(h.data);
      end
    end else if (m_wait && tick) begin
      wait_left--;
      if (wait_left == 0) m_wait = 0;
    end
    if (accepted) mq.push_back({cmd_wait, cmd_addr, cmd_data});
    @(posedge clk);
    cyc++;
    #1;
    if (sid_we) begin
      we_seen++;
      prev_we_cyc = last_we_cyc;
      last_we_cyc = cyc;
    end
    check_output();
  endtask

  task automatic idle(int n);
    repeat (n) apply_stimulus();
  endtask

  task automatic push_cmd(bit w, logic [4:0] a, logic [15:0] d);
    int n = 0;
    cmd_valid = 1;
    cmd_wait = w;
    cmd_addr = a;
    cmd_data = d;
    do begin
      apply_stimulus();
      n++;
    end while (!accepted && n < 300);
    cmd_valid = 0;
    chk("push_accepted", 32'(accepted), 32'd1);
  endtask

  initial begin
    // Reset state
    #1;
    model_clear();
    check_output();
    @(posedge clk);
    #1;
    reset = 0;
    #1;
    chk("ready_after_reset", 32'(cmd_ready), 32'd1);
    #1;

    // Three back-to-back writes, no ticks
    $display("[TB] back-to-back writes");
    tick_period = 0;
    we_seen = 0;
    push_cmd(0, 5'h00, 16'h0005);
    push_cmd(0, 5'h01, 16'h0024);
    push_cmd(0, 5'h04, 16'h0021);
    idle(4);
    chk("b2b_we_count", 32'(we_seen), 32'd3);

    // Write, wait 3 on a slow tick, write
    $display("[TB] wait of three ticks");
    tick_period = 4;
    we_seen = 0;
    push_cmd(0, 5'h04, 16'h0041);
    push_cmd(1, 5'h00, 16'd3);
    push_cmd(0, 5'h04, 16'h0040);
    idle(24);
    chk("wait3_we_count", 32'(we_seen), 32'd2);

    // Fill past depth behind a long wait
    $display("[TB] full FIFO backpressure");
    tick_period = 1;
    we_seen = 0;
    push_cmd(1, 5'h00, 16'd100);
    for (int i = 0; i < 8; i++) push_cmd(0, 5'(i), 16'(8'h30 + i));
    chk("full_level", 32'(level), 32'd8);
    push_cmd(0, 5'h08, 16'h0038);
    idle(15);
    chk("full_we_count", 32'(we_seen), 32'd9);

    // Single-cycle flush during a wait with five entries queued
    $display("[TB] flush during wait");
    tick_period = 0;
    push_cmd(1, 5'h00, 16'd50);
    for (int i = 0; i < 5; i++) push_cmd(0, 5'(i + 2), 16'(8'h50 + i));
    idle(2);
    we_seen = 0;
    flush = 1;
    apply_stimulus();
    flush = 0;
    chk("flush_level", 32'(level), 32'd0);
    chk("flush_mute_a", 32'(sid_a), 32'(REG_VOLUME));
    idle(10);
    chk("flush_we_count", 32'(we_seen), 32'd1);

    // Flush held three cycles while a command is offered
    we_seen = 0;
    flush = 1;
    cmd_valid = 1;
    cmd_wait = 0;
    cmd_addr = 5'h02;
    cmd_data = 16'h00AA;
    idle(3);
    flush = 0;
    cmd_valid = 0;
    idle(3);
    chk("flush_hold_we_count", 32'(we_seen), 32'd3);

    // Zero wait acts as a NOP between two writes
    $display("[TB] zero wait NOP");
    we_seen = 0;
    push_cmd(0, 5'h05, 16'h0011);
    push_cmd(1, 5'h00, 16'd0);
    push_cmd(0, 5'h06, 16'h0022);
    idle(4);
    chk("nop_we_count", 32'(we_seen), 32'd2);
    chk("nop_gap", 32'(last_we_cyc - prev_we_cyc), 32'd2);

    // Asynchronous reset in the middle of a wait
    $display("[TB] reset mid-wait");
    push_cmd(1, 5'h00, 16'd20);
    push_cmd(0, 5'h07, 16'h0033);
    push_cmd(0, 5'h08, 16'h0044);
    idle(2);
    #3;
    reset = 1;
    #1;
    model_clear();
    check_output();
    @(posedge clk);
    #1;
    reset = 0;
    we_seen = 0;
    idle(10);
    chk("post_reset_we_count", 32'(we_seen), 32'd0);

    // Randomized traffic
    $display("[TB] random traffic");
    tick_period = 3;
    for (int i = 0; i < 400; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_wait = ($urandom_range(0, 3) == 0);
      cmd_addr = 5'($urandom_range(0, 31));
      cmd_data = cmd_wait ? 16'($urandom_range(0, 6)) : 16'($urandom);
      flush = ($urandom_range(0, 39) == 0);
      apply_stimulus();
    end
    cmd_valid = 0;
    flush = 0;
    idle(60);
    chk("random_drained", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sid_write_sequencer.md
SID_WRITE_SEQUENCER -- requirements
Module: sid_write_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, command FIFO entries (power of two, 2..64).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port tick  input  1  single-cycle timebase strobe for wait counting (e.g. 1 MHz phi2 enable).
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when cmd_valid and cmd_ready both high.
REQ-007 SHALL have port cmd_wait  input  1  0 = register write, 1 = wait.
REQ-008 SHALL have port cmd_addr  input  5  SID register address (write only).
REQ-009 SHALL have port cmd_data  input  16  write: [7:0] = data, [15:8] ignored; wait: tick count.
REQ-010 SHALL have port flush  input  1  abort and mute request.
REQ-011 SHALL have ports sid_a (output, 5) and sid_di (output, 8), the SID bus address and data.
REQ-012 SHALL have ports sid_we and sid_cs (outputs, 1 each); both are high together for exactly one cycle per write.
REQ-013 SHALL have port busy  output  1  FIFO non-empty or waiting.
REQ-014 SHALL have port level  output  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.

Function
REQ-015 Command entries SHALL be stored in a synchronous FIFO as {wait, addr[4:0], data[15:0]} (22 bits).
REQ-016 cmd_ready SHALL equal !full && !flush; there is no pass-through when full, even with a simultaneous pop.
REQ-017 A push and a pop in the same cycle SHALL leave level unchanged.
REQ-018 The FSM SHALL have states IDLE and WAIT.
REQ-019 In IDLE with the FIFO non-empty and flush low, the head entry SHALL be popped in that cycle.
REQ-020 Popped write entry: next cycle sid_we = sid_cs = 1, sid_a = addr, sid_di = data[7:0]; state stays IDLE, so back-to-back writes sustain one write per clock.
REQ-021 Popped wait entry with count 0: no write; state stays IDLE (acts as a NOP).
REQ-022 Popped wait entry with count N>0: load a 16-bit counter with N and enter WAIT.
REQ-023 In WAIT: decrement the counter on each tick; on the tick that reaches 0, return to IDLE the next cycle.
REQ-024 A wait of N SHALL therefore consume exactly N tick strobes; ticks outside WAIT are ignored.
REQ-025 No FIFO pop SHALL occur while in WAIT.
REQ-026 When no write is issued, sid_we = sid_cs = 0; sid_a and sid_di hold their last values.
REQ-027 flush SHALL have the highest priority in any state:
- FIFO emptied and counter cleared;
- no pop that cycle;
- state forced to IDLE;
- next cycle a single mute write is issued: sid_a = 5'h18, sid_di = 8'h00, sid_we = 1.
REQ-028 flush held for multiple cycles SHALL produce one mute write per cycle held; pushes are refused throughout.
REQ-029 flush coinciding with a pop-eligible head SHALL discard that head, and no write from it is issued.
REQ-030 busy SHALL equal (level != 0) || (state == WAIT).

Reset
REQ-031 Asynchronous reset SHALL force:
- state IDLE, FIFO empty, level 0, counter 0;
- sid_we = sid_cs = 0, sid_a = 0, sid_di = 0;
- busy = 0; cmd_ready = 1 once reset deasserts.
REQ-032 Reset mid-WAIT or mid-burst SHALL discard all pending commands and issue no write.

Structure
REQ-033 The shared package sid_pkg SHALL hold the SID register address constants (REG_VOLUME = 5'h18, voice/filter bases), the FSM state enum, and the command entry struct/width constant.
REQ-034 The FIFO SHALL be a separate sub-module sid_cmd_fifo (parameterised depth and width, with a flush port and level output); the FSM, counter and bus registers live in the top module.

Verification
REQ-035 Push writes (00,05), (01,24), (04,21) back-to-back, tick low -> sid_we high on three consecutive cycles with sid_a/sid_di = 00/05, 01/24, 04/21; level returns to 0; busy falls the cycle after the last pop.
REQ-036 Push write (04,41), wait 3, write (04,40); tick every 4th clock -> second write appears only after the 3rd tick following WAIT entry; exactly 2 sid_we pulses.
REQ-037 Push 9 commands with FIFO_DEPTH=8 and wait 100 at head -> cmd_ready drops at level 8; the 9th is accepted only after a pop; nothing is lost.
REQ-038 Assert flush for 1 cycle during WAIT with 5 entries queued -> level 0, busy 0, exactly one write 18/00 the next cycle, none of the queued writes issued.
REQ-039 Push wait 0 between two writes -> the writes are 2 cycles apart, and no sid_we occurs for the NOP.
REQ-040 Assert reset mid-WAIT with entries queued -> all outputs at reset values immediately; no sid_we after release until new commands are pushed.
